// File: rtl/rgb_scan_pkg.sv
// rgb_scan_pkg: shared types and helpers for the RGB LCD scan-out block.
package rgb_scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } scan_state_t;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    // Counter width needed to hold 0..total-1.
    function automatic int cnt_w(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/rgb_axis_cnt.sv
// rgb_axis_cnt: 0-based wrap counter with terminal-count flag (one per axis).
module rgb_axis_cnt #(
    parameter int TOTAL = 8,
    parameter int W     = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         tc
);

    assign tc = (32'(cnt) == TOTAL - 1);

    // Count up on inc, wrap to 0 after TOTAL-1; clr holds the counter at 0.
    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (inc)
            cnt <= tc ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/rgb_scan_out.sv
// rgb_scan_out: paces RGB565 FIFO reads to the active region and drives a
// parallel LCD with HS/VS/DE. Optional underflow pixel counter is enabled by
// defining RGB_UFLOW_CNT_EN.
module rgb_scan_out
    import rgb_scan_pkg::*;
#(
    parameter int          H_ACTIVE = 480,
    parameter int          H_FP     = 2,
    parameter int          H_SYNC   = 41,
    parameter int          H_BP     = 2,
    parameter int          V_ACTIVE = 272,
    parameter int          V_FP     = 2,
    parameter int          V_SYNC   = 10,
    parameter int          V_BP     = 2,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0,
    parameter logic [15:0] FILL_RGB = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] fifo_do,
    input  logic        fifo_empty,
    output logic        fifo_re,
    output logic        lcd_hs,
    output logic        lcd_vs,
    output logic        lcd_de,
    output logic [4:0]  lcd_r,
    output logic [5:0]  lcd_g,
    output logic [4:0]  lcd_b,
    output logic        busy,
`ifdef RGB_UFLOW_CNT_EN
    output logic [15:0] uflow_cnt,
`endif
    output logic        uflow
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = cnt_w(H_TOTAL);
    localparam int VW      = cnt_w(V_TOTAL);
    localparam int STAGES  = 2;

    scan_state_t state, state_nx;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic h_tc, v_tc, run, frame_end;
    logic active0, hs0, vs0, under0;

    // vld_pipe[1] = active1, vld_pipe[2] = lcd_de
    logic [STAGES:1] vld_pipe;
    logic took1, hs1, vs1;
    rgb565_t pix;

    assign run       = (state == RUN);
    assign frame_end = h_tc && v_tc;
    assign busy      = (state != IDLE);

    rgb_axis_cnt #(.TOTAL(H_TOTAL), .W(HW)) u_h_cnt (
        .clk(clk), .rst(rst), .clr(!run), .inc(run),
        .cnt(h_cnt), .tc(h_tc)
    );

    rgb_axis_cnt #(.TOTAL(V_TOTAL), .W(VW)) u_v_cnt (
        .clk(clk), .rst(rst), .clr(!run), .inc(run && h_tc),
        .cnt(v_cnt), .tc(v_tc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state: start waits for data, stop only at the last clock of a frame.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (en) state_nx = PRIME;
            PRIME:   if (!en) state_nx = IDLE;
                     else if (!fifo_empty) state_nx = RUN;
            RUN:     if (frame_end && !en) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Stage 0: region decode from the counters; read only when data is there.
    always_comb begin
        active0 = run && (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
        hs0     = (32'(h_cnt) >= H_ACTIVE + H_FP) && (32'(h_cnt) < H_ACTIVE + H_FP + H_SYNC);
        vs0     = (32'(v_cnt) >= V_ACTIVE + V_FP) && (32'(v_cnt) < V_ACTIVE + V_FP + V_SYNC);
        under0  = active0 && fifo_empty;
        fifo_re = active0 && !fifo_empty;
    end

    // Stages 1 and 2: fifo_do arrives with took1, so colour is picked at stage 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            took1    <= 1'b0;
            hs1      <= 1'b0;
            vs1      <= 1'b0;
            pix      <= '0;
            lcd_hs   <= ~HS_POL;
            lcd_vs   <= ~VS_POL;
        end else begin
            vld_pipe[1] <= active0;
            took1       <= fifo_re;
            hs1         <= hs0;
            vs1         <= vs0;
            vld_pipe[2] <= vld_pipe[1];
            if (took1)            pix <= rgb565_t'(fifo_do);
            else if (vld_pipe[1]) pix <= rgb565_t'(FILL_RGB);
            else                  pix <= '0;
            lcd_hs <= hs1 ? HS_POL : ~HS_POL;
            lcd_vs <= vs1 ? VS_POL : ~VS_POL;
        end
    end

    assign lcd_de = vld_pipe[2];
    assign lcd_r  = pix.r;
    assign lcd_g  = pix.g;
    assign lcd_b  = pix.b;

    // Sticky underflow flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst)         uflow <= 1'b0;
        else if (under0) uflow <= 1'b1;
    end

`ifdef RGB_UFLOW_CNT_EN
    // Saturating count of fill-colour pixels.
    always_ff @(posedge clk) begin
        if (rst)                                uflow_cnt <= '0;
        else if (under0 && uflow_cnt != 16'hFFFF) uflow_cnt <= uflow_cnt + 16'd1;
    end
`endif

endmodule
